snail_stream_gen: RTL and testbench
===================================

Name: snail_stream_gen

Overview:
- Bit-serial stimulus transmitter: the source side of the single-bit `number` stream that the snail pattern-detector FSMs consume.
- Accepts a parallel WIDTH-bit word through a valid/ready handshake.
- Shifts the word out MSB-first, one bit per clock, and optionally repeats it a programmable number of times with a one-cycle gap between passes.
- Feeds detector blocks directly in lab/bench top levels.

Parameters:
- WIDTH, 8, number of bits per word; legal range 1..32.
- REP_W, 4, width of the repeat-count input; maximum passes is 2^REP_W.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset); deassertion is synchronous to clk by system design.
- load_valid  input  1  requester has a word on data/repeat_cnt.
- load_ready  output  1  block can accept a word; high only in IDLE.
- data  input  WIDTH  word to serialize; sampled on the accept edge.
- repeat_cnt  input  REP_W  extra passes after the first; 0 means send once; sampled on the accept edge.
- number  output  1  serial bit out; 0 whenever bit_valid=0.
- bit_valid  output  1  number carries a payload bit this cycle.
- busy  output  1  high in SHIFT and GAP.
- done  output  1  one-cycle pulse after the final bit of the final pass.

Behaviour:
- Reset (reset=0, asynchronous) forces:
  - state to IDLE, and shift register, saved word, bit counter and pass counter to 0;
  - number=0, bit_valid=0, busy=0, done=0, load_ready=1 (IDLE value).
- FSM states: IDLE, SHIFT, GAP, DONE.
- All outputs are Moore: decoded from state and registers only, never directly from inputs.
- Accept:
  - a word is accepted on the rising edge where load_valid=1 and load_ready=1;
  - data is copied into both the shift register and the saved word, and repeat_cnt into the pass counter;
  - the bit counter is set to WIDTH-1 and the state goes IDLE->SHIFT.
- load_valid while load_ready=0 is ignored; no queuing, and data is not sampled.
- SHIFT:
  - number = shift_reg[WIDTH-1], bit_valid=1, busy=1;
  - each cycle the register shifts left by one (0 filled) and the bit counter decrements.
- When the bit counter is 0 in SHIFT (last bit of the pass):
  - if pass counter != 0: go to GAP and decrement the pass counter;
  - if pass counter == 0: go to DONE.
- GAP:
  - exactly one cycle; number=0, bit_valid=0, busy=1;
  - the shift register reloads from the saved word, the bit counter goes to WIDTH-1, and the state returns to SHIFT.
- DONE:
  - exactly one cycle; done=1, busy=0, load_ready=0; then IDLE.
- Latency and cycle counts:
  - first payload bit appears in the cycle after the accept edge;
  - total SHIFT+GAP cycles = (repeat_cnt+1)*WIDTH + repeat_cnt;
  - done follows the last payload bit by exactly one cycle.
- Back-to-back: the next accept is possible on the first IDLE cycle after DONE, so the minimum inter-word spacing is one IDLE cycle plus one DONE cycle.
- WIDTH=1: each pass is a single SHIFT cycle; GAP/DONE rules are unchanged.
- repeat_cnt at max (2^REP_W-1): 2^REP_W passes and no counter wrap; the pass counter never decrements below 0.
- Reset mid-operation (any state): immediate return to IDLE and all outputs to reset values; no done pulse.
- Unused state encodings recover to IDLE on the next clock.

Test Plan:
- Reset pulse low for 2 cycles, then load_valid=1, data=8'b1011_0010, repeat_cnt=0 -> load_ready drops the cycle after accept; number=1,0,1,1,0,0,1,0 over 8 cycles with bit_valid=1; done=1 in cycle 9; load_ready=1 in cycle 10.
- data=8'hA5, repeat_cnt=2 -> three passes 10100101, each separated by one cycle of bit_valid=0/number=0; busy high for 26 cycles; one done pulse.
- load_valid held high with data=8'h3C during an active transfer of 8'hF0 -> 8'h3C is not sampled; output stream is exactly F0; 8'h3C is accepted only on the next IDLE cycle.
- reset driven low at the 4th bit of data=8'hFF, repeat_cnt=3 -> number, bit_valid and busy go 0 immediately (asynchronously); no done pulse; load_ready=1; a fresh word afterwards serializes correctly.
- WIDTH=1 build, data=1, repeat_cnt=15 -> 16 single-bit passes of 1 with a gap between each; busy high for 31 cycles; done after the last bit.
- Drive number into a snail detector with data=8'b1101_0000, repeat_cnt=0 -> detector smile asserts on the cycle predicted by its transition table.

Source files
------------

// File: rtl/snail_stream_gen.sv
// snail_stream_gen: bit-serial stimulus source for the snail pattern detectors.
// Accepts a parallel word over a valid/ready handshake and shifts it out
// MSB-first, optionally repeating it with a single idle cycle between passes.
module snail_stream_gen #(
    parameter int WIDTH = 8,
    parameter int REP_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] data,
    input  logic [REP_W-1:0] repeat_cnt,
    output logic             number,
    output logic             bit_valid,
    output logic             busy,
    output logic             done
);

    // A one-bit word still needs a one-bit counter, so clamp the width at 1.
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] saved_word;
    logic [CNT_W-1:0] bit_cnt;
    logic [REP_W-1:0] pass_cnt;

    // State register; reset returns to IDLE without ever passing through DONE.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode and Moore outputs, derived only from state and registers.
    always_comb begin
        next_state = state;
        load_ready = 1'b0;
        number     = 1'b0;
        bit_valid  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    next_state = SHIFT;
                end
            end
            SHIFT: begin
                number    = shift_reg[WIDTH-1];
                bit_valid = 1'b1;
                busy      = 1'b1;
                if (bit_cnt == '0) begin
                    next_state = (pass_cnt != '0) ? GAP : DONE;
                end
            end
            GAP: begin
                busy       = 1'b1;
                next_state = SHIFT;
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Datapath: capture on accept, shift during SHIFT, reload the saved word in GAP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_reg  <= '0;
            saved_word <= '0;
            bit_cnt    <= '0;
            pass_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        shift_reg  <= data;
                        saved_word <= data;
                        pass_cnt   <= repeat_cnt;
                        bit_cnt    <= LAST_BIT;
                    end
                end
                SHIFT: begin
                    shift_reg <= shift_reg << 1;
                    if (bit_cnt != '0) begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end else if (pass_cnt != '0) begin
                        pass_cnt <= pass_cnt - REP_W'(1);
                    end
                end
                GAP: begin
                    shift_reg <= saved_word;
                    bit_cnt   <= LAST_BIT;
                end
                default: begin
                    shift_reg <= shift_reg;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snail_stream_gen.sv
// tb_snail_stream_gen: drives words into snail_stream_gen and compares the
// serial stream, handshake and status outputs against a queue-based model.
module tb_snail_stream_gen;

    localparam int WIDTH = 8;
    localparam int REP_W = 4;

    logic             clk;
    logic             reset;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] data;
    logic [REP_W-1:0] repeat_cnt;
    logic             number;
    logic             bit_valid;
    logic             busy;
    logic             done;

    logic             load_valid1;
    logic             load_ready1;
    logic [0:0]       data1;
    logic [REP_W-1:0] repeat_cnt1;
    logic             number1;
    logic             bit_valid1;
    logic             busy1;
    logic             done1;

    int compareCount  = 0;
    int mismatchCount = 0;

    snail_stream_gen #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .data       (data),
        .repeat_cnt (repeat_cnt),
        .number     (number),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done)
    );

    snail_stream_gen #(.WIDTH(1), .REP_W(REP_W)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid1),
        .load_ready (load_ready1),
        .data       (data1),
        .repeat_cnt (repeat_cnt1),
        .number     (number1),
        .bit_valid  (bit_valid1),
        .busy       (busy1),
        .done       (done1)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
        end
    endtask

    // Status bundle {busy, bit_valid, number, load_ready, done} for compact checks.
    function automatic logic [31:0] statusVec();
        return {27'd0, busy, bit_valid, number, load_ready, done};
    endfunction

    // Sends one word from an IDLE negedge and checks every cycle until the
    // following IDLE negedge. The expected stream is built as a list of
    // {bit_valid, number} pairs: each pass is the word MSB-first, passes are
    // separated by one empty slot.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input int rep,
                                 input bit holdLoad, input logic [WIDTH-1:0] holdData);
        logic [1:0] expQ[$];
        int busyCycles;
        expQ = {};
        for (int p = 0; p <= rep; p++) begin
            for (int i = WIDTH - 1; i >= 0; i--) expQ.push_back({1'b1, word[i]});
            if (p < rep) expQ.push_back(2'b00);
        end
        checkOutput("idle_ready", statusVec(), 32'b00010);
        load_valid = 1'b1;
        data       = word;
        repeat_cnt = REP_W'(rep);
        @(posedge clk);
        @(negedge clk);
        load_valid = holdLoad;
        data       = holdData;
        busyCycles = 0;
        foreach (expQ[k]) begin
            checkOutput($sformatf("stream_%0h_r%0d_c%0d", word, rep, k), statusVec(),
                        {27'd0, 1'b1, expQ[k], 2'b00});
            if (busy) busyCycles++;
            @(negedge clk);
        end
        checkOutput("busy_cycles", busyCycles, (rep + 1) * WIDTH + rep);
        checkOutput("done_pulse", statusVec(), 32'b00001);
        @(negedge clk);
        checkOutput("back_to_idle", statusVec(), 32'b00010);
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] w;
        int r;
        int busyCnt1;

        reset       = 1'b0;
        load_valid  = 1'b0;
        data        = '0;
        repeat_cnt  = '0;
        load_valid1 = 1'b0;
        data1       = '0;
        repeat_cnt1 = '0;

        // Reset held for two cycles; outputs must sit at their IDLE values.
        @(negedge clk);
        checkOutput("reset_state", statusVec(), 32'b00010);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        $display("[TB] directed single word B2");
        applyStimulus(8'b1011_0010, 0, 1'b0, '0);

        $display("[TB] directed A5 with two repeats");
        applyStimulus(8'hA5, 2, 1'b0, '0);

        $display("[TB] load held during active F0 transfer");
        applyStimulus(8'hF0, 0, 1'b1, 8'h3C);
        applyStimulus(8'h3C, 0, 1'b0, '0);

        $display("[TB] maximum repeat count");
        applyStimulus(8'h81, (1 << REP_W) - 1, 1'b0, '0);

        // Asynchronous reset in the middle of the fourth payload bit.
        $display("[TB] reset mid-transfer");
        load_valid = 1'b1;
        data       = 8'hFF;
        repeat_cnt = 4'd3;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        for (int i = 0; i < 3; i++) @(negedge clk);
        checkOutput("fourth_bit", statusVec(), 32'b11100);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_reset", statusVec(), 32'b00010);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checkOutput("held_reset", statusVec(), 32'b00010);
        end
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", statusVec(), 32'b00010);
        end
        applyStimulus(8'b1101_0000, 0, 1'b0, '0);

        $display("[TB] randomized back-to-back words");
        for (int n = 0; n < 20; n++) begin
            w = WIDTH'($urandom);
            r = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
            applyStimulus(w, r, 1'b0, '0);
        end

        // One-bit build: sixteen single-bit passes separated by gaps.
        $display("[TB] WIDTH=1 instance, sixteen passes");
        checkOutput("w1_idle", {busy1, bit_valid1, number1, load_ready1, done1}, 5'b00010);
        load_valid1 = 1'b1;
        data1       = 1'b1;
        repeat_cnt1 = 4'd15;
        @(posedge clk);
        @(negedge clk);
        load_valid1 = 1'b0;
        busyCnt1 = 0;
        for (int c = 0; c < 31; c++) begin
            checkOutput($sformatf("w1_cycle_%0d", c), {busy1, bit_valid1, number1, load_ready1, done1},
                        {1'b1, (c % 2 == 0), (c % 2 == 0), 2'b00});
            if (busy1) busyCnt1++;
            @(negedge clk);
        end
        checkOutput("w1_busy_cycles", busyCnt1, 31);
        checkOutput("w1_done", {busy1, bit_valid1, number1, load_ready1, done1}, 5'b00001);
        @(negedge clk);
        checkOutput("w1_idle_after", {busy1, bit_valid1, number1, load_ready1, done1}, 5'b00010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
